rf_write_arbiter: RTL and testbench

Arbitrates the register file's single write port between the in-order writeback (WB) stage and the out-of-order multi-cycle unit (MDU: mul/div). Buffers MDU results in a small FIFO and tracks MDU-pending destination registers in a scoreboard for hazard detection. Applies a starvation guard that briefly stalls WB. Sits between the WB stage, the MDU result port and the register file write inputs.

---
 rtl/rf_write_arbiter_pkg.sv | 17 +
 rtl/rf_wr_fifo.sv | 66 ++++++
 rtl/rf_write_arbiter.sv | 128 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int RF_DATA_W  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One register-file write request as presented to the write port.
  typedef struct packed {
    logic                 we;
    reg_addr_t            rd;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Parameterised synchronous FIFO with full/empty flags and a head output.
// DEPTH must be a power of two and at least 2. Push while full and pop
// while empty are ignored.
module rf_wr_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int W     = REG_ADDR_W + RF_DATA_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
  end

  // Pointer and occupancy registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the occupancy count alone decides which entries are valid.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and the
// out-of-order MDU. MDU results are buffered in rf_wr_fifo; a scoreboard of
// MDU-pending destinations drives the busy flags for hazard detection.
// Optional feature macro RF_ARB_STARVE_GUARD_EN: when defined, an MDU result
// denied STARVE_LIMIT consecutive cycles is forced in and WB is stalled for
// that cycle. When undefined, the MDU drains only on cycles WB leaves idle.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int N            = RF_DATA_W,
  parameter int MDU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [N-1:0]          wb_data,
  output logic                  wb_stall,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [N-1:0]          mdu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  rf_regwrite,
  output logic [REG_ADDR_W-1:0] rf_writereg,
  output logic [N-1:0]          rf_writedata
);

  localparam int ENTRY_W = REG_ADDR_W + N;

  logic                  wb_eff;
  logic                  fifo_full, fifo_empty, fifo_push;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [N-1:0]          head_data;
  logic                  force_grant, mdu_grant;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  rf_wr_req_t            wr_req;

  // Writes to x0 are no-ops and never compete for the port.
  assign wb_eff    = wb_we && (wb_rd != '0);
  assign mdu_ready = !fifo_full;
  // An x0 result completes its handshake but is dropped before the FIFO.
  assign fifo_push = mdu_valid && mdu_ready && (mdu_rd != '0);
  assign {head_rd, head_data} = fifo_head;

  rf_wr_fifo #(
    .W     (ENTRY_W),
    .DEPTH (MDU_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (mdu_grant),
    .data_i  ({mdu_rd, mdu_data}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The buffered MDU result wins whenever WB is idle or the guard forces it.
  assign mdu_grant = !fifo_empty && (!wb_eff || force_grant);

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_grant = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign wb_stall    = wb_eff && mdu_grant;

  // Count consecutive cycles a queued result is denied; saturate at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || mdu_grant) starve_cnt_d = '0;
    else if (!force_grant)       starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_grant = 1'b0;
  assign wb_stall    = 1'b0;
`endif

  // Write-port mux: MDU head on a grant, otherwise the WB request.
  always_comb begin
    wr_req = '0;
    if (mdu_grant) begin
      wr_req.rd   = head_rd;
      wr_req.data = RF_DATA_W'(head_data);
    end else begin
      wr_req.rd   = wb_rd;
      wr_req.data = RF_DATA_W'(wb_data);
    end
    wr_req.we = !rst && (mdu_grant || wb_eff);
  end

  assign rf_regwrite  = wr_req.we;
  assign rf_writereg  = wr_req.rd;
  assign rf_writedata = N'(wr_req.data);

  // Scoreboard update: clear the written rd, then set the issued rd so a same-rd set wins.
  always_comb begin
    pending_d = pending_q;
    if (mdu_grant)                         pending_d[head_rd]  = 1'b0;
    if (issue_valid && (issue_rd != '0))   pending_d[issue_rd] = 1'b1;
  end

  // Scoreboard register; reset discards all pending reservations.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign busy_rs1 = (rs1 != '0) && pending_q[rs1];
  assign busy_rs2 = (rs2 != '0) && pending_q[rs2];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int N     = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we, mdu_valid, issue_valid;
  logic [4:0]    wb_rd, mdu_rd, issue_rd, rs1, rs2;
  logic [N-1:0]  wb_data, mdu_data;
  logic          wb_stall, mdu_ready, busy_rs1, busy_rs2, rf_regwrite;
  logic [4:0]    rf_writereg;
  logic [N-1:0]  rf_writedata;

  int cmp_n  = 0;
  int fail_n = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.N(N), .MDU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg), .rf_writedata(rf_writedata)
  );

  // Reference model: queue of buffered results, pending set, denied-cycle run length.
  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit [31:0]   m_pend;
  int          m_starve;
  logic        e_grant, e_stall, e_ready, e_we, e_b1, e_b2;
  logic [4:0]  e_reg;
  logic [N-1:0] e_data;

  task automatic predict();
    bit wb_eff, forced;
    wb_eff = wb_we && (wb_rd != 0);
`ifdef RF_ARB_STARVE_GUARD_EN
    forced = (m_starve >= LIMIT);
`else
    forced = 1'b0;
`endif
    e_grant = (m_q.size() > 0) && (!wb_eff || forced);
    e_stall = wb_eff && e_grant;
    e_ready = (m_q.size() < DEPTH);
    e_we    = !rst && (e_grant || wb_eff);
    e_reg   = e_grant ? m_q[0].rd : wb_rd;
    e_data  = e_grant ? m_q[0].data : wb_data;
    e_b1    = (rs1 != 0) && m_pend[rs1];
    e_b2    = (rs2 != 0) && m_pend[rs2];
  endtask

  // Advance one clock: model follows the edge, inputs then change at negedge.
  task automatic tick();
    bit was_empty;
    predict();
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_pend   = '0;
      m_starve = 0;
    end else begin
      was_empty = (m_q.size() == 0);
      if (e_grant) begin
        m_pend[m_q[0].rd] = 1'b0;
        void'(m_q.pop_front());
      end
      if (mdu_valid && e_ready && (mdu_rd != 0)) m_q.push_back('{rd: mdu_rd, data: mdu_data});
      if (issue_valid && (issue_rd != 0)) m_pend[issue_rd] = 1'b1;
      if (e_grant || was_empty)  m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_data = '0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = '0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && m_q.size() > 0; i++) tick();
    cmp_n++; if (m_q.size() != 0) begin fail_n++; $display("FAIL drain_timeout: %0d entries left, want 0", m_q.size()); end
  endtask

  task automatic test_reset();
    idle(); rst = 1; rs1 = 5; rs2 = 9;
    #1;
    cmp_n++; if (rf_regwrite !== 1'b0) begin fail_n++; $display("FAIL reset_regwrite_in_rst: got %b want 0", rf_regwrite); end
    tick(); tick();
    rst = 0; #1;
    cmp_n++; if (mdu_ready !== 1'b1)   begin fail_n++; $display("FAIL reset_ready: got %b want 1", mdu_ready); end
    cmp_n++; if (wb_stall !== 1'b0)    begin fail_n++; $display("FAIL reset_stall: got %b want 0", wb_stall); end
    cmp_n++; if (rf_regwrite !== 1'b0) begin fail_n++; $display("FAIL reset_regwrite: got %b want 0", rf_regwrite); end
    cmp_n++; if ({busy_rs1, busy_rs2} !== 2'b00) begin fail_n++; $display("FAIL reset_busy: got %b want 00", {busy_rs1, busy_rs2}); end
    tick();
  endtask

  task automatic test_wb_only();
    idle(); wb_we = 1; wb_rd = 5; wb_data = 32'hA5; rs1 = 5; rs2 = 3;
    for (int c = 0; c < 3; c++) begin
      #1;
      cmp_n++; if (rf_regwrite !== 1'b1) begin fail_n++; $display("FAIL wb_regwrite c%0d: got %b want 1", c, rf_regwrite); end
      cmp_n++; if (rf_writereg !== 5'd5 || rf_writedata !== 32'hA5) begin fail_n++; $display("FAIL wb_target c%0d: got r%0d=%h want r5=a5", c, rf_writereg, rf_writedata); end
      cmp_n++; if ({wb_stall, busy_rs1, busy_rs2} !== 3'b000) begin fail_n++; $display("FAIL wb_flags c%0d: got %b want 000", c, {wb_stall, busy_rs1, busy_rs2}); end
      tick();
    end
    idle();
  endtask

  task automatic test_mdu_basic();
    idle(); rs1 = 7; rs2 = 0; issue_valid = 1; issue_rd = 7; #1;
    cmp_n++; if (busy_rs1 !== 1'b0) begin fail_n++; $display("FAIL mdu_busy_before_issue: got %b want 0", busy_rs1); end
    tick();
    issue_valid = 0; mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h1234; #1;
    cmp_n++; if (busy_rs1 !== 1'b1)    begin fail_n++; $display("FAIL mdu_busy_after_issue: got %b want 1", busy_rs1); end
    cmp_n++; if (rf_regwrite !== 1'b0) begin fail_n++; $display("FAIL mdu_no_passthrough: got %b want 0", rf_regwrite); end
    tick();
    mdu_valid = 0; #1;
    cmp_n++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd7 || rf_writedata !== 32'h1234) begin fail_n++; $display("FAIL mdu_write: got we=%b r%0d=%h want we=1 r7=1234", rf_regwrite, rf_writereg, rf_writedata); end
    cmp_n++; if (busy_rs1 !== 1'b1) begin fail_n++; $display("FAIL mdu_busy_during_write: got %b want 1", busy_rs1); end
    tick(); #1;
    cmp_n++; if (busy_rs1 !== 1'b0 || rf_regwrite !== 1'b0) begin fail_n++; $display("FAIL mdu_after_write: got busy=%b we=%b want 0 0", busy_rs1, rf_regwrite); end
    tick();
  endtask

  task automatic test_starvation();
    int stalls = 0, writes9 = 0, first9 = -1;
    idle(); rs1 = 9; rs2 = 3;
    wb_we = 1; wb_rd = 3; wb_data = 32'hDEAD0003;
    issue_valid = 1; issue_rd = 9; mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h0909;
    tick();
    issue_valid = 0; mdu_valid = 0; #1;
    cmp_n++; if (busy_rs1 !== 1'b1) begin fail_n++; $display("FAIL starve_busy9: got %b want 1", busy_rs1); end
`ifdef RF_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) #1;
      if (rf_regwrite && rf_writereg == 5'd9) begin writes9++; if (first9 < 0) first9 = k; end
      if (wb_stall) stalls++;
      if (k == 1) begin
        cmp_n++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd3) begin fail_n++; $display("FAIL starve_denied_wb: got we=%b r%0d want we=1 r3", rf_regwrite, rf_writereg); end
      end
      if (first9 > 0 && k == first9 + 1) begin
        cmp_n++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd3 || rf_writedata !== 32'hDEAD0003) begin fail_n++; $display("FAIL starve_wb_lands: got we=%b r%0d=%h want we=1 r3=dead0003", rf_regwrite, rf_writereg, rf_writedata); end
      end
      tick();
    end
    cmp_n++; if (first9 != LIMIT + 1) begin fail_n++; $display("FAIL starve_force_cycle: got %0d want %0d", first9, LIMIT + 1); end
    cmp_n++; if (stalls != 1 || writes9 != 1) begin fail_n++; $display("FAIL starve_stall_count: got stalls=%0d writes9=%0d want 1 1", stalls, writes9); end
`else
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) #1;
      if (rf_regwrite && rf_writereg == 5'd9) writes9++;
      if (wb_stall) stalls++;
      tick();
    end
    cmp_n++; if (stalls != 0 || writes9 != 0) begin fail_n++; $display("FAIL noguard_no_force: got stalls=%0d writes9=%0d want 0 0", stalls, writes9); end
    wb_we = 0; #1;
    cmp_n++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd9 || rf_writedata !== 32'h0909) begin fail_n++; $display("FAIL noguard_drain: got we=%b r%0d=%h want we=1 r9=909", rf_regwrite, rf_writereg, rf_writedata); end
    tick();
`endif
    drain(); #1;
    cmp_n++; if (busy_rs1 !== 1'b0) begin fail_n++; $display("FAIL starve_busy9_clear: got %b want 0", busy_rs1); end
  endtask

  task automatic test_fifo_full();
    idle(); wb_we = 1; wb_rd = 3; wb_data = 32'h33;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hA0; #1;
    cmp_n++; if (mdu_ready !== 1'b1) begin fail_n++; $display("FAIL full_ready_c0: got %b want 1", mdu_ready); end
    tick();
    mdu_rd = 11; mdu_data = 32'hB0; #1;
    cmp_n++; if (mdu_ready !== 1'b1) begin fail_n++; $display("FAIL full_ready_c1: got %b want 1", mdu_ready); end
    tick();
    mdu_rd = 12; mdu_data = 32'hC0; #1;
    cmp_n++; if (mdu_ready !== 1'b0) begin fail_n++; $display("FAIL full_ready_c2: got %b want 0", mdu_ready); end
    tick();
    wb_we = 0; #1;
    cmp_n++; if (mdu_ready !== 1'b0) begin fail_n++; $display("FAIL full_ready_on_deq: got %b want 0", mdu_ready); end
    cmp_n++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd10 || rf_writedata !== 32'hA0) begin fail_n++; $display("FAIL full_first_out: got we=%b r%0d=%h want we=1 r10=a0", rf_regwrite, rf_writereg, rf_writedata); end
    tick(); #1;
    cmp_n++; if (mdu_ready !== 1'b1 || rf_writereg !== 5'd11) begin fail_n++; $display("FAIL full_ready_back: got ready=%b r%0d want 1 r11", mdu_ready, rf_writereg); end
    tick();
    mdu_valid = 0; #1;
    cmp_n++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd12 || rf_writedata !== 32'hC0) begin fail_n++; $display("FAIL full_third_out: got we=%b r%0d=%h want we=1 r12=c0", rf_regwrite, rf_writereg, rf_writedata); end
    tick();
    drain();
  endtask

  task automatic test_set_wins_and_rd0();
    idle(); rs1 = 4; rs2 = 0;
    issue_valid = 1; issue_rd = 4; mdu_valid = 1; mdu_rd = 4; mdu_data = 32'h4001;
    tick();
    mdu_valid = 0; #1;
    cmp_n++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd4) begin fail_n++; $display("FAIL setwins_write: got we=%b r%0d want we=1 r4", rf_regwrite, rf_writereg); end
    tick();
    issue_valid = 0; #1;
    cmp_n++; if (busy_rs1 !== 1'b1) begin fail_n++; $display("FAIL setwins_pending: got %b want 1", busy_rs1); end
    mdu_valid = 1; mdu_rd = 4; mdu_data = 32'h4002;
    tick();
    mdu_valid = 0; #1;
    cmp_n++; if (rf_writereg !== 5'd4 || rf_writedata !== 32'h4002) begin fail_n++; $display("FAIL setwins_second: got r%0d=%h want r4=4002", rf_writereg, rf_writedata); end
    tick(); #1;
    cmp_n++; if (busy_rs1 !== 1'b0) begin fail_n++; $display("FAIL setwins_clear: got %b want 0", busy_rs1); end
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'hBAD0; #1;
    cmp_n++; if (mdu_ready !== 1'b1) begin fail_n++; $display("FAIL rd0_ready: got %b want 1", mdu_ready); end
    tick();
    mdu_valid = 0; #1;
    cmp_n++; if (rf_regwrite !== 1'b0 || mdu_ready !== 1'b1) begin fail_n++; $display("FAIL rd0_dropped: got we=%b ready=%b want 0 1", rf_regwrite, mdu_ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); wb_we = 1; wb_rd = 3; wb_data = 32'h3;
    issue_valid = 1; issue_rd = 20; mdu_valid = 1; mdu_rd = 20; mdu_data = 32'h20;
    tick();
    issue_rd = 21; mdu_rd = 21; mdu_data = 32'h21;
    tick();
    issue_valid = 0; mdu_valid = 0; rs1 = 20; rs2 = 21; #1;
    cmp_n++; if ({busy_rs1, busy_rs2, mdu_ready} !== 3'b110) begin fail_n++; $display("FAIL rstmid_before: got busy/ready %b want 110", {busy_rs1, busy_rs2, mdu_ready}); end
    rst = 1; #1;
    cmp_n++; if (rf_regwrite !== 1'b0) begin fail_n++; $display("FAIL rstmid_no_write: got %b want 0", rf_regwrite); end
    tick();
    rst = 0; wb_we = 0; #1;
    cmp_n++; if ({mdu_ready, busy_rs1, busy_rs2, rf_regwrite} !== 4'b1000) begin fail_n++; $display("FAIL rstmid_after: got ready/busy/we %b want 1000", {mdu_ready, busy_rs1, busy_rs2, rf_regwrite}); end
    tick(); #1;
    cmp_n++; if (rf_regwrite !== 1'b0) begin fail_n++; $display("FAIL rstmid_discarded: got %b want 0", rf_regwrite); end
    tick();
  endtask

  task automatic test_random();
    bit hold;
    logic [4:0] r;
    idle();
    for (int c = 0; c < 600; c++) begin
      hold = e_stall && !rst;
      rst = ($urandom_range(0, 63) == 0);
      if (!hold) begin
        wb_we = ($urandom_range(0, 9) < 6); wb_rd = 5'($urandom()); wb_data = $urandom();
      end
      mdu_valid = ($urandom_range(0, 9) < 4); mdu_rd = 5'($urandom()); mdu_data = $urandom();
      r = 5'($urandom());
      issue_valid = ($urandom_range(0, 4) == 0) && !m_pend[r]; issue_rd = r;
      rs1 = 5'($urandom()); rs2 = 5'($urandom());
      #1; predict();
      cmp_n++; if ({rf_regwrite, wb_stall, mdu_ready} !== {e_we, e_stall, e_ready}) begin fail_n++; $display("FAIL rand_ctrl c%0d: got we/stall/ready %b want %b", c, {rf_regwrite, wb_stall, mdu_ready}, {e_we, e_stall, e_ready}); end
      cmp_n++; if ({busy_rs1, busy_rs2} !== {e_b1, e_b2}) begin fail_n++; $display("FAIL rand_busy c%0d: got %b want %b", c, {busy_rs1, busy_rs2}, {e_b1, e_b2}); end
      if (!rst) begin
        cmp_n++; if (rf_writereg !== e_reg || rf_writedata !== e_data) begin fail_n++; $display("FAIL rand_port c%0d: got r%0d=%h want r%0d=%h", c, rf_writereg, rf_writedata, e_reg, e_data); end
      end
      tick();
    end
    rst = 0;
    drain();
  endtask

  initial begin
    m_q.delete(); m_pend = '0; m_starve = 0;
    test_reset();
    test_wb_only();
    test_mdu_basic();
    test_starvation();
    test_fifo_full();
    test_set_wins_and_rd0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
